// File: rtl/alu_pkg.sv
// Shared ALU control constants: op encodings, dispatch FSM states and unit count.
// The result mux select decodes these same op values.
package alu_pkg;

  localparam int NUM_UNITS = 8;
  localparam int OPW       = 3;

  localparam logic [OPW-1:0] OP_AND  = 3'b000;
  localparam logic [OPW-1:0] OP_OR   = 3'b001;
  localparam logic [OPW-1:0] OP_ADD  = 3'b010;
  localparam logic [OPW-1:0] OP_SLT  = 3'b011;
  localparam logic [OPW-1:0] OP_MUL  = 3'b100;
  localparam logic [OPW-1:0] OP_XOR  = 3'b101;
  localparam logic [OPW-1:0] OP_SLL  = 3'b110;
  localparam logic [OPW-1:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Only the add/sub unit interprets the subtract qualifier.
  function automatic logic sub_qualify(input logic [OPW-1:0] op, input logic sub);
    return (op == OP_ADD) && sub;
  endfunction

endpackage

// File: rtl/alu_op_onehot.sv
// Op code to one-hot unit start vector; all-zero when not enabled.
module alu_op_onehot
  import alu_pkg::*;
(
  input  logic                 en,
  input  logic [OPW-1:0]       op,
  output logic [NUM_UNITS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[op] = 1'b1;
  end

endmodule

// File: rtl/alu_op_dispatch.sv
// Dispatches one ALU op at a time: latches the select, pulses the matching unit start,
// waits for that unit's done (or times out) and holds the response until it is taken.
module alu_op_dispatch
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OPW-1:0]       req_op,
  input  logic                 req_sub,
  output logic [OPW-1:0]       sel,
  output logic                 sub,
  output logic [NUM_UNITS-1:0] start,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_err,
  output logic [CNTW-1:0]      rsp_cycles
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [OPW-1:0]  sel_q;
  logic            sub_q;
  logic [CNTW-1:0] cnt;
  logic            err_q;
  logic [CNTW-1:0] cycles_q;

  logic accept;
  logic wait_done;
  logic wait_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Done is checked before the timeout so a completion on the last allowed cycle still counts.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    wait_done    = 1'b0;
    wait_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = (req_op == OP_RSVD) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (unit_done[sel_q]) begin
          wait_done = 1'b1;
          state_nxt = ST_RESP;
        end else if (cnt == CNT_LAST) begin
          wait_timeout = 1'b1;
          state_nxt    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= OP_AND;
      sub_q    <= 1'b0;
      cnt      <= '0;
      err_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      if (accept) begin
        sel_q    <= req_op;
        sub_q    <= sub_qualify(req_op, req_sub);
        err_q    <= (req_op == OP_RSVD);
        cycles_q <= '0;
      end
      if (state == ST_ISSUE) begin
        cnt <= '0;
      end else if ((state == ST_WAIT) && !wait_done && !wait_timeout) begin
        cnt <= cnt + CNTW'(1);
      end
      if (wait_done) begin
        err_q    <= 1'b0;
        cycles_q <= cnt + CNTW'(1);
      end else if (wait_timeout) begin
        err_q    <= 1'b1;
        cycles_q <= '0;
      end
    end
  end

  // Start is decoded from state, so an async reset drops it without waiting for a clock.
  alu_op_onehot u_start_dec (
    .en     (state == ST_ISSUE),
    .op     (sel_q),
    .onehot (start)
  );

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign sel        = sel_q;
  assign sub        = sub_q;
  assign rsp_err    = err_q;
  assign rsp_cycles = cycles_q;

  a_start_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(start));
  a_start_issue_only : assert property (@(posedge clk) disable iff (!rst_n)
    (start != '0) |-> (state == ST_ISSUE));
  a_sel_stable_resp : assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_RESP) && !rsp_ready |=> $stable(sel) && $stable(rsp_cycles) && $stable(rsp_err));

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Randomised self-checking bench for alu_op_dispatch against a transaction-level model
// of when the response appears and what it carries.
module tb_alu_op_dispatch;

  localparam int TIMEOUT = 16;
  localparam int CNTW    = 8;
  localparam int NO_DONE = 255;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_op = 3'b000;
  logic            req_sub = 1'b0;
  logic [2:0]      sel;
  logic            sub;
  logic [7:0]      start;
  logic [7:0]      unit_done = 8'h00;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic            rsp_err;
  logic [CNTW-1:0] rsp_cycles;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  alu_op_dispatch #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_sub    (req_sub),
    .sel        (sel),
    .sub        (sub),
    .start      (start),
    .unit_done  (unit_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_err    (rsp_err),
    .rsp_cycles (rsp_cycles)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h required %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One transaction starting at a negedge in IDLE. d = cycles from start pulse to the unit's
  // done (NO_DONE for never). noise adds foreign done bits, a done during the start cycle
  // and request garbage while busy. Returns positioned at a negedge back in IDLE.
  task automatic applyStimulus(input logic [2:0] op, input logic s, input int d,
                               input int hold, input logic noise);
    logic [7:0] oh;
    logic [7:0] ud;
    int         tRsp;
    logic       expErr;
    int         expCycles;
    oh = 8'h01 << op;
    if (op == 3'b111)     tRsp = 1;
    else if (d <= TIMEOUT) tRsp = d + 2;
    else                   tRsp = TIMEOUT + 2;
    expErr    = (op == 3'b111) || (d > TIMEOUT);
    expCycles = expErr ? 0 : d;

    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_sub   = s;
    unit_done = 8'h00;

    for (int t = 1; t <= tRsp; t++) begin
      @(negedge clk);
      req_valid = noise ? 1'($urandom) : 1'b0;
      req_op    = 3'($urandom);
      req_sub   = 1'($urandom);
      checkOutput("start", 32'(start), (t == 1 && op != 3'b111) ? 32'(oh) : 32'd0);
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(t == tRsp));
      checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
      checkOutput("sel_hold", 32'(sel), 32'(op));
      ud = noise ? (8'($urandom) & ~oh) : 8'h00;
      if (op != 3'b111 && t == 1 + d) ud = ud | oh;
      if (noise && t == 1) ud = ud | oh;
      if (t == tRsp) ud = 8'h00;
      unit_done = ud;
    end

    checkOutput("sub", 32'(sub), 32'((op == 3'b010) && s));
    checkOutput("rsp_err", 32'(rsp_err), 32'(expErr));
    checkOutput("rsp_cycles", 32'(rsp_cycles), 32'(expCycles));
    rsp_ready = (hold == 0);

    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      req_valid = noise ? 1'($urandom) : 1'b0;
      req_op    = 3'($urandom);
      checkOutput("rsp_valid_hold", 32'(rsp_valid), 32'd1);
      checkOutput("sel_resp_hold", 32'(sel), 32'(op));
      checkOutput("cycles_hold", 32'(rsp_cycles), 32'(expCycles));
      if (h == hold) rsp_ready = 1'b1;
    end

    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checkOutput("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    checkOutput("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  // Start an op 100 that never completes and pull reset tRst cycles after accept
  // (tRst = 1 is during the start pulse).
  task automatic resetDuring(input int tRst);
    req_valid = 1'b1;
    req_op    = 3'b100;
    req_sub   = 1'b0;
    for (int t = 1; t <= tRst; t++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    if (tRst == 1) checkOutput("start_pre_reset", 32'(start), 32'h10);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_start", 32'(start), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_sel", 32'(sel), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] op;
    int         d;
    repeat (2) @(negedge clk);
    checkOutput("reset_start", 32'(start), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_sel", 32'(sel), 32'd0);
    checkOutput("reset_sub", 32'(sub), 32'd0);
    checkOutput("reset_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_cycles", 32'(rsp_cycles), 32'd0);

    $display("[TB] directed operations");
    applyStimulus(3'b000, 1'b0, 1, 0, 1'b0);
    applyStimulus(3'b010, 1'b1, 1, 0, 1'b0);
    applyStimulus(3'b011, 1'b1, 2, 1, 1'b0);
    applyStimulus(3'b100, 1'b0, 4, 5, 1'b0);
    applyStimulus(3'b111, 1'b1, NO_DONE, 0, 1'b0);
    applyStimulus(3'b110, 1'b0, NO_DONE, 2, 1'b1);
    applyStimulus(3'b101, 1'b0, TIMEOUT, 0, 1'b1);
    applyStimulus(3'b001, 1'b0, TIMEOUT + 1, 0, 1'b0);

    $display("[TB] reset mid-operation");
    resetDuring(4);
    applyStimulus(3'b001, 1'b0, 1, 0, 1'b0);
    resetDuring(1);
    applyStimulus(3'b010, 1'b0, 3, 0, 1'b1);

    $display("[TB] randomised operations");
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      d  = ($urandom_range(0, 7) == 0) ? NO_DONE : int'($urandom_range(1, TIMEOUT + 3));
      applyStimulus(op, 1'($urandom), d, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
